// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative AES core: load, key handshake, initial AddRoundKey,
// Nr rounds (encrypt or decrypt) and read-out, each matrix pass split into BEATS beats.
module aes_round_sequencer #(
  parameter int BEATS = 4,
  parameter int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_write_n,
  input  logic             start_read_n,
  input  logic             mode_dec,
  input  logic [1:0]       key_len,
  input  logic             key_expand_done,
  input  logic             hold,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             key_start,
  output logic [1:0]       key_len_q,
  output logic             inv_op,
  output logic [3:0]       matrix_in_sel,
  output logic             matrix_write_enable,
  output logic             in_row_col,
  output logic             out_row_col,
  output logic [IDX_W-1:0] in_idx,
  output logic [IDX_W-1:0] out_idx,
  output logic [3:0]       rk_idx,
  output logic [5:0]       dbg_state,
  output logic [3:0]       dbg_round
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD     = 4'd1,
    KEY_WAIT = 4'd2,
    ARK0     = 4'd3,
    SUB      = 4'd4,
    SHIFT    = 4'd5,
    MIX      = 4'd6,
    ARK      = 4'd7,
    DONE     = 4'd8,
    READ     = 4'd9
  } state_t;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] beat, beat_d;
  logic [3:0]       round, round_d;
  logic             key_rdy, key_rdy_d;
  logic             inv_op_d;
  logic [1:0]       key_len_d;
  logic [3:0]       nr;
  logic             last_beat, final_round, stallable, writing, step, phase_end;

  always_comb begin
    case (key_len_q)
      2'b01:   nr = 4'd12;
      2'b10:   nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end

  assign stallable   = (state == LOAD) || (state == ARK0) || (state == SUB) || (state == SHIFT) ||
                       (state == MIX) || (state == ARK) || (state == READ);
  assign writing     = stallable && (state != READ);
  assign last_beat   = (beat == LAST_BEAT);
  assign final_round = (round == nr);
  assign step        = stallable && !hold;
  assign phase_end   = step && last_beat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat      <= '0;
      round     <= 4'd0;
      key_rdy   <= 1'b0;
      inv_op    <= 1'b0;
      key_len_q <= 2'b00;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      round     <= round_d;
      key_rdy   <= key_rdy_d;
      inv_op    <= inv_op_d;
      key_len_q <= key_len_d;
    end
  end

  // Round ends on ARK for encrypt (MIX precedes it) and on MIX for decrypt (MIX follows ARK).
  always_comb begin
    state_d   = state;
    beat_d    = beat;
    round_d   = round;
    key_rdy_d = key_rdy;
    inv_op_d  = inv_op;
    key_len_d = key_len_q;
    if (step) beat_d = last_beat ? '0 : beat + 1'b1;
    if ((state == LOAD || state == KEY_WAIT) && key_expand_done) key_rdy_d = 1'b1;
    case (state)
      IDLE: begin
        key_rdy_d = 1'b0;
        if (!start_write_n) begin
          state_d   = LOAD;
          inv_op_d  = mode_dec;
          key_len_d = (key_len == 2'b11) ? 2'b00 : key_len;
          beat_d    = '0;
          round_d   = 4'd0;
        end
      end
      LOAD:     if (phase_end) state_d = (key_rdy || key_expand_done) ? ARK0 : KEY_WAIT;
      KEY_WAIT: if (key_expand_done) state_d = ARK0;
      ARK0: if (phase_end) begin
        round_d = 4'd1;
        state_d = inv_op ? SHIFT : SUB;
      end
      SUB:   if (phase_end) state_d = inv_op ? ARK : SHIFT;
      SHIFT: if (phase_end) state_d = inv_op ? SUB : (final_round ? ARK : MIX);
      MIX: if (phase_end) begin
        if (inv_op) begin
          round_d = round + 4'd1;
          state_d = SHIFT;
        end else begin
          state_d = ARK;
        end
      end
      ARK: if (phase_end) begin
        if (final_round) begin
          state_d = DONE;
        end else if (inv_op) begin
          state_d = MIX;
        end else begin
          round_d = round + 4'd1;
          state_d = SUB;
        end
      end
      DONE: if (!start_read_n) state_d = READ;
      READ: if (phase_end) state_d = IDLE;
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        round_d = 4'd0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_d   = IDLE;
      beat_d    = '0;
      round_d   = 4'd0;
      key_rdy_d = 1'b0;
    end
  end

  always_comb begin
    matrix_in_sel = 4'd0;
    in_row_col    = 1'b0;
    case (state)
      LOAD:      in_row_col = 1'b1;
      ARK0, ARK: begin
        matrix_in_sel = 4'd4;
        in_row_col    = 1'b1;
      end
      SUB:       matrix_in_sel = 4'd1;
      SHIFT:     matrix_in_sel = 4'd2;
      MIX: begin
        matrix_in_sel = 4'd3;
        in_row_col    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy                = (state != IDLE) && (state != DONE);
  assign done                = (state == DONE);
  assign key_start           = (state == LOAD) && (beat == '0) && !hold && !abort;
  assign matrix_write_enable = writing && !hold && !abort;
  assign out_row_col         = (state == READ) || in_row_col;
  assign in_idx              = writing ? beat : '0;
  assign out_idx             = beat;
  assign rk_idx              = (state == IDLE) ? 4'd0 : (inv_op ? (nr - round) : round);
  assign dbg_state           = {2'b00, state};
  assign dbg_round           = round;

endmodule
